// File: rtl/jtdsp16_loop_seq.sv
// Do-loop sequencer and instruction cache for the DSP16 core.
// Records the loop body from program ROM on the first pass. It then replays the
// body from local storage for the remaining passes, holding the PC meanwhile.
// Optional redo support (replay the last stored body) is enabled by defining
// the macro JTDSP16_REDO_EN.
module jtdsp16_loop_seq #(
   parameter int unsigned DEPTH = 15,
   parameter int unsigned AW    = 4,
   parameter int unsigned CW    = 7,
   parameter int unsigned DW    = 16
) (
   input  logic          rst,
   input  logic          clk,
   input  logic          cen,
   input  logic          do_start,
   input  logic [AW-1:0] do_ni,
   input  logic [CW-1:0] do_k,
   input  logic          ins_adv,
   input  logic [DW-1:0] rom_dout,
   output logic [DW-1:0] ins_dout,
   output logic          cache_sel,
   output logic          pc_hold,
   output logic          busy,
   output logic          no_int,
   output logic [CW-1:0] iter_left,
   output logic          fault
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] DepthW = AW'(DEPTH);

   typedef enum logic [1:0] {StIdle, StFill, StReplay} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] ni_q, ni_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] iter_q, iter_d;
   logic          fault_q, fault_d;
   logic [DW-1:0] cache [DEPTH];

   logic          ni_ok;
   logic [CW-1:0] k_eff;

   assign ni_ok = (do_ni != '0) && (do_ni <= DepthW);
   // A zero iteration count behaves like a single pass
   assign k_eff = (do_k == '0) ? CW'(1) : do_k;

   // Next-state logic for the loop controller
   always_comb begin
      state_d  = state_q;
      ni_d     = ni_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      iter_d   = iter_q;
      fault_d  = fault_q;
      unique case (state_q)
         StIdle: begin
            if (do_start) begin
               if (ni_ok) begin
                  ni_d     = do_ni;
                  iter_d   = k_eff;
                  wr_ptr_d = '0;
                  state_d  = StFill;
               end
`ifdef JTDSP16_REDO_EN
               else if (do_ni == '0 && ni_q != '0) begin
                  iter_d   = k_eff;
                  rd_ptr_d = '0;
                  state_d  = StReplay;
               end else begin
                  fault_d = 1'b1;
               end
`else
               else begin
                  fault_d = 1'b1;
               end
`endif
            end
         end
         StFill: begin
            // Any request while busy is refused, including one on the final word
            if (do_start) fault_d = 1'b1;
            if (ins_adv) begin
               if (wr_ptr_q == ni_q - AW'(1)) begin
                  if (iter_q > CW'(1)) begin
                     state_d  = StReplay;
                     rd_ptr_d = '0;
                     iter_d   = iter_q - CW'(1);
                  end else begin
                     state_d = StIdle;
                     iter_d  = '0;
                  end
               end else begin
                  wr_ptr_d = wr_ptr_q + AW'(1);
               end
            end
         end
         StReplay: begin
            if (do_start) fault_d = 1'b1;
            if (ins_adv) begin
               if (rd_ptr_q == ni_q - AW'(1)) begin
                  if (iter_q == CW'(1)) begin
                     state_d = StIdle;
                     iter_d  = '0;
                  end else begin
                     rd_ptr_d = '0;
                     iter_d   = iter_q - CW'(1);
                  end
               end else begin
                  rd_ptr_d = rd_ptr_q + AW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Control state registers, advanced only on clock-enable
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         ni_q     <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         iter_q   <= '0;
         fault_q  <= 1'b0;
      end else if (cen) begin
         state_q  <= state_d;
         ni_q     <= ni_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         iter_q   <= iter_d;
         fault_q  <= fault_d;
      end
   end

   // Body capture during the first pass; storage needs no reset
   always_ff @(posedge clk) begin
      if (cen && state_q == StFill && ins_adv) cache[wr_ptr_q[PW-1:0]] <= rom_dout;
   end

   // Status outputs and the zero-latency instruction source mux
   always_comb begin
      busy      = (state_q != StIdle);
      no_int    = busy;
      cache_sel = (state_q == StReplay);
      pc_hold   = cache_sel;
      iter_left = iter_q;
      fault     = fault_q;
      ins_dout  = rst ? '0 : (cache_sel ? cache[rd_ptr_q[PW-1:0]] : rom_dout);
   end

endmodule

// File: tb/tb_jtdsp16_loop_seq.sv
// Self-checking bench for jtdsp16_loop_seq: directed loops plus random traffic,
// compared every cycle against a word-count based reference model.
module tb_jtdsp16_loop_seq;

   localparam int unsigned DEPTH = 15;
   localparam int unsigned AW    = 5;
   localparam int unsigned CW    = 7;
   localparam int unsigned DW    = 16;
`ifdef JTDSP16_REDO_EN
   localparam bit REDO = 1'b1;
`else
   localparam bit REDO = 1'b0;
`endif

   logic          rst, clk, cen, do_start, ins_adv;
   logic [AW-1:0] do_ni;
   logic [CW-1:0] do_k;
   logic [DW-1:0] rom_dout, ins_dout;
   logic          cache_sel, pc_hold, busy, no_int, fault;
   logic [CW-1:0] iter_left;

   int checks = 0;
   int errors = 0;

   // Reference model: a loop is NI*K consumed words; pass 1 comes from ROM
   // unless it is a redo, and word n of any cached pass is body[n % NI].
   bit            m_busy, m_redo, m_fault;
   int            m_ni, m_k, m_done, m_stored;
   logic [DW-1:0] m_body [DEPTH];

   jtdsp16_loop_seq #(.DEPTH(DEPTH), .AW(AW), .CW(CW), .DW(DW)) dut (
      .rst(rst), .clk(clk), .cen(cen), .do_start(do_start), .do_ni(do_ni),
      .do_k(do_k), .ins_adv(ins_adv), .rom_dout(rom_dout), .ins_dout(ins_dout),
      .cache_sel(cache_sel), .pc_hold(pc_hold), .busy(busy), .no_int(no_int),
      .iter_left(iter_left), .fault(fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_redo = 0; m_fault = 0;
      m_ni = 1; m_k = 0; m_done = 0; m_stored = 0;
   endtask

   task automatic check_all();
      bit            sel;
      logic [DW-1:0] dout;
      int            it;
      sel  = m_busy && (m_redo || m_done >= m_ni);
      dout = rst ? '0 : (sel ? m_body[m_done % m_ni] : rom_dout);
      it   = m_busy ? m_k - m_done / m_ni : 0;
      check_eq("ins_dout", 32'(ins_dout), 32'(dout));
      check_eq("cache_sel", 32'(cache_sel), 32'(sel));
      check_eq("pc_hold", 32'(pc_hold), 32'(sel));
      check_eq("busy", 32'(busy), 32'(m_busy));
      check_eq("no_int", 32'(no_int), 32'(m_busy));
      check_eq("iter_left", 32'(iter_left), 32'(it));
      check_eq("fault", 32'(fault), 32'(m_fault));
   endtask

   task automatic model_step();
      int kk;
      if (!cen) return;
      if (m_busy) begin
         if (do_start) m_fault = 1;
         if (ins_adv) begin
            if (!m_redo && m_done < m_ni) m_body[m_done] = rom_dout;
            m_done++;
            if (m_done == m_k * m_ni) m_busy = 0;
         end
      end else if (do_start) begin
         kk = (do_k == 0) ? 1 : int'(do_k);
         if (do_ni >= 1 && do_ni <= DEPTH) begin
            m_busy = 1; m_redo = 0; m_ni = int'(do_ni); m_k = kk; m_done = 0;
            m_stored = int'(do_ni);
         end else if (do_ni == 0 && REDO && m_stored != 0) begin
            m_busy = 1; m_redo = 1; m_ni = m_stored; m_k = kk; m_done = 0;
         end else begin
            m_fault = 1;
         end
      end
   endtask

   // One clock: drive at the falling edge, check shortly after, step model at rise
   task automatic drive(input bit c, input bit s, input int ni, input int k, input bit a);
      @(negedge clk);
      cen = c; do_start = s; do_ni = AW'(ni); do_k = CW'(k); ins_adv = a;
      rom_dout = DW'($urandom);
      #1 check_all();
      @(posedge clk);
      #0 model_step();
   endtask

   task automatic advance(input int n);
      for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 1);
   endtask

   // Asynchronous reset pulse away from any clock edge
   task automatic async_reset();
      @(negedge clk);
      #2 rst = 1'b1; cen = 1'b0; do_start = 1'b0; ins_adv = 1'b0; rom_dout = '0;
      model_reset();
      #1 check_all();
      @(posedge clk);
      @(negedge clk) rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cen = 1'b0; do_start = 1'b0; ins_adv = 1'b0;
      do_ni = '0; do_k = '0; rom_dout = '0;
      model_reset();
      #3 check_all();
      @(negedge clk) rst = 1'b0;

      // NI=3, K=4: one fill pass plus three replays
      drive(1, 1, 3, 4, 0);
      advance(13);
      // NI=2, K=1: fill only, never replayed
      drive(1, 1, 2, 1, 0);
      advance(3);
      // Body length beyond capacity is refused
      drive(1, 1, 16, 2, 0);
      advance(2);
      async_reset();
      // Full-depth body, two passes
      drive(1, 1, 15, 2, 0);
      advance(31);
      async_reset();
      // Request during replay is refused; stall mid-replay keeps everything frozen
      drive(1, 1, 2, 5, 0);
      advance(3);
      drive(1, 1, 3, 1, 1);
      advance(2);
      for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 1);
      advance(5);
      async_reset();
      // Reset in the middle of a replay
      drive(1, 1, 3, 3, 0);
      advance(5);
      async_reset();
      drive(1, 0, 0, 0, 1);
      // Request on the final word of a loop is refused
      drive(1, 1, 1, 2, 0);
      drive(1, 0, 0, 0, 1);
      drive(1, 1, 4, 2, 1);
      advance(2);
      async_reset();
      // Redo of the last body (refused without redo support)
      drive(1, 1, 2, 2, 0);
      advance(4);
      drive(1, 1, 0, 3, 0);
      advance(7);
      async_reset();

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 79) == 0) async_reset();
         drive($urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
               int'($urandom_range(0, 17)), int'($urandom_range(0, 4)),
               $urandom_range(0, 3) != 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
